// File: rtl/cur_blk_sched.sv
// Walks a CU in raster-ordered 4x4 sub-blocks: issues cur_data row reads, captures the rows, hands them downstream.
// One sub-block per RD_LAT+2 cycles; no new read is issued while a captured sub-block waits for blk_ready.
module cur_blk_sched #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [5:0]        i_cu_w_blk,
    input  logic [5:0]        i_cu_h_blk,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cur_en,
    output logic              o_cur_export,
    output logic [ADDR_W-1:0] o_cur_addr0,
    output logic [ADDR_W-1:0] o_cur_addr1,
    output logic [ADDR_W-1:0] o_cur_addr2,
    output logic [ADDR_W-1:0] o_cur_addr3,
    input  logic [DATA_W-1:0] i_cur_data0,
    input  logic [DATA_W-1:0] i_cur_data1,
    input  logic [DATA_W-1:0] i_cur_data2,
    input  logic [DATA_W-1:0] i_cur_data3,
    output logic              o_blk_valid,
    input  logic              i_blk_ready,
    output logic [DATA_W-1:0] o_blk_data0,
    output logic [DATA_W-1:0] o_blk_data1,
    output logic [DATA_W-1:0] o_blk_data2,
    output logic [DATA_W-1:0] o_blk_data3,
    output logic [4:0]        o_blk_x,
    output logic [4:0]        o_blk_y,
    output logic              o_blk_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_FIN
    } state_t;

    localparam logic [2:0] LP_LAST_WAIT = 3'(RD_LAT - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [5:0]        r_w;
    logic [5:0]        r_h;
    logic [4:0]        r_bx;
    logic [4:0]        r_by;
    logic [ADDR_W-1:0] r_rp;
    logic [ADDR_W-1:0] r_row_start;
    logic [2:0]        r_wait_cnt;
    logic              r_blk_valid;
    logic              r_blk_last;
    logic [DATA_W-1:0] r_blk_data0;
    logic [DATA_W-1:0] r_blk_data1;
    logic [DATA_W-1:0] r_blk_data2;
    logic [DATA_W-1:0] r_blk_data3;

    logic              w_abort;
    logic              w_start_acc;
    logic              w_zero_dim;
    logic              w_rd_last;
    logic              w_capture;
    logic              w_hs;
    logic              w_col_end;
    logic              w_row_end;
    logic [ADDR_W-1:0] w_w_ext;
    logic [ADDR_W-1:0] w_row_step;

    assign w_abort     = i_abort && (r_state != S_IDLE);
    assign w_start_acc = i_start && (r_state == S_IDLE);
    assign w_zero_dim  = (i_cu_w_blk == 6'd0) || (i_cu_h_blk == 6'd0);
    assign w_rd_last   = (r_wait_cnt == LP_LAST_WAIT);
    assign w_capture   = (r_state == S_WAIT) && w_rd_last && !w_abort;
    assign w_hs        = (r_state == S_HOLD) && r_blk_valid && i_blk_ready && !w_abort;
    assign w_col_end   = ({1'b0, r_bx} == (r_w - 6'd1));
    assign w_row_end   = ({1'b0, r_by} == (r_h - 6'd1));
    assign w_w_ext     = ADDR_W'(r_w);
    assign w_row_step  = w_w_ext << 2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = w_zero_dim ? S_FIN : S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_rd_last) w_state_nxt = S_HOLD;
            S_HOLD:  if (r_blk_valid && i_blk_ready) w_state_nxt = r_blk_last ? S_FIN : S_ISSUE;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // abort wins over start and the downstream handshake
        if (w_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_w         <= '0;
            r_h         <= '0;
            r_bx        <= '0;
            r_by        <= '0;
            r_rp        <= '0;
            r_row_start <= '0;
            r_wait_cnt  <= '0;
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
            r_blk_data0 <= '0;
            r_blk_data1 <= '0;
            r_blk_data2 <= '0;
            r_blk_data3 <= '0;
        end else begin
            if (w_start_acc) begin
                r_w         <= i_cu_w_blk;
                r_h         <= i_cu_h_blk;
                r_bx        <= '0;
                r_by        <= '0;
                r_rp        <= i_base_addr;
                r_row_start <= i_base_addr;
            end

            if ((r_state == S_WAIT) && !w_rd_last && !w_abort) begin
                r_wait_cnt <= r_wait_cnt + 3'd1;
            end else begin
                r_wait_cnt <= '0;
            end

            if (w_capture) begin
                r_blk_valid <= 1'b1;
                r_blk_last  <= w_col_end && w_row_end;
                r_blk_data0 <= i_cur_data0;
                r_blk_data1 <= i_cur_data1;
                r_blk_data2 <= i_cur_data2;
                r_blk_data3 <= i_cur_data3;
            end

            if (w_hs) begin
                r_blk_valid <= 1'b0;
                if (!r_blk_last) begin
                    // row_start is kept separately so a row wrap never depends on bx
                    if (w_col_end) begin
                        r_bx        <= '0;
                        r_by        <= r_by + 5'd1;
                        r_row_start <= r_row_start + w_row_step;
                        r_rp        <= r_row_start + w_row_step;
                    end else begin
                        r_bx <= r_bx + 5'd1;
                        r_rp <= r_rp + ADDR_W'(1);
                    end
                end
            end

            if (w_abort) begin
                r_blk_valid <= 1'b0;
            end
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_cur_en     = o_busy;
    assign o_done       = (r_state == S_FIN);
    assign o_cur_export = (r_state == S_ISSUE);
    assign o_cur_addr0  = r_rp;
    assign o_cur_addr1  = r_rp + w_w_ext;
    assign o_cur_addr2  = r_rp + (w_w_ext << 1);
    assign o_cur_addr3  = r_rp + w_w_ext + (w_w_ext << 1);
    assign o_blk_valid  = r_blk_valid;
    assign o_blk_data0  = r_blk_data0;
    assign o_blk_data1  = r_blk_data1;
    assign o_blk_data2  = r_blk_data2;
    assign o_blk_data3  = r_blk_data3;
    assign o_blk_x      = r_bx;
    assign o_blk_y      = r_by;
    assign o_blk_last   = r_blk_last;

endmodule

// File: tb/tb_cur_blk_sched.sv
// Bench for cur_blk_sched: RAM responder, formula-based sub-block model, and handshake scoreboard.
module tb_cur_blk_sched;

    typedef struct {
        logic [51:0]  a;
        logic [127:0] d;
        logic [4:0]   x;
        logic [4:0]   y;
        logic         last;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [5:0]  cu_w_blk;
    logic [5:0]  cu_h_blk;
    logic [12:0] base_addr;
    logic        busy, done, cur_en, cur_export;
    logic [12:0] cur_addr0, cur_addr1, cur_addr2, cur_addr3;
    logic [31:0] cur_data0, cur_data1, cur_data2, cur_data3;
    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] blk_data0, blk_data1, blk_data2, blk_data3;
    logic [4:0]  blk_x, blk_y;
    logic        blk_last;

    logic [31:0] mem [0:8191];
    item_t       sb[$];
    int          exports[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          done_cnt = 0;
    int          done_rel = 0;
    int          busy_cnt = 0;
    logic [51:0] last_a;
    logic        last_last;
    logic        rand_rdy = 1'b0;

    cur_blk_sched #(.ADDR_W(13), .DATA_W(32), .RD_LAT(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_cu_w_blk(cu_w_blk), .i_cu_h_blk(cu_h_blk), .i_base_addr(base_addr),
        .o_busy(busy), .o_done(done), .o_cur_en(cur_en), .o_cur_export(cur_export),
        .o_cur_addr0(cur_addr0), .o_cur_addr1(cur_addr1),
        .o_cur_addr2(cur_addr2), .o_cur_addr3(cur_addr3),
        .i_cur_data0(cur_data0), .i_cur_data1(cur_data1),
        .i_cur_data2(cur_data2), .i_cur_data3(cur_data3),
        .o_blk_valid(blk_valid), .i_blk_ready(blk_ready),
        .o_blk_data0(blk_data0), .o_blk_data1(blk_data1),
        .o_blk_data2(blk_data2), .o_blk_data3(blk_data3),
        .o_blk_x(blk_x), .o_blk_y(blk_y), .o_blk_last(blk_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM responder: rows valid exactly one cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        if (cur_export === 1'b1) begin
            cur_data0 <= mem[cur_addr0];
            cur_data1 <= mem[cur_addr1];
            cur_data2 <= mem[cur_addr2];
            cur_data3 <= mem[cur_addr3];
        end else begin
            cur_data0 <= $urandom;
            cur_data1 <= $urandom;
            cur_data2 <= $urandom;
            cur_data3 <= $urandom;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        item_t it;
        if (rst_n === 1'b1) begin
            if (busy) busy_cnt++;
            if (cur_export) exports.push_back(cyc - t0);
            if (blk_valid && blk_ready) begin
                last_a    = {cur_addr0, cur_addr1, cur_addr2, cur_addr3};
                last_last = blk_last;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_blk: got block (%0d,%0d), expected none", blk_x, blk_y);
                end else begin
                    it = sb.pop_front();
                    chk("blk_addr", 128'(last_a), 128'(it.a));
                    chk("blk_data", {blk_data0, blk_data1, blk_data2, blk_data3}, it.d);
                    chk("blk_xy_last", 128'({blk_x, blk_y, blk_last}), 128'({it.x, it.y, it.last}));
                end
            end
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) blk_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Reference: sub-block (x,y) row k lives at base + 4*w*y + x + k*w, mod 2^13
    task automatic push_cu(input int w, input int h, input int base, input int limit);
        item_t       it;
        int          n;
        int          r;
        logic [12:0] ak [4];
        n = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (n < limit) begin
                    r = base + y * 4 * w + x;
                    for (int k = 0; k < 4; k++) ak[k] = 13'((r + k * w) % 8192);
                    it.a    = {ak[0], ak[1], ak[2], ak[3]};
                    it.d    = {mem[ak[0]], mem[ak[1]], mem[ak[2]], mem[ak[3]]};
                    it.x    = 5'(x);
                    it.y    = 5'(y);
                    it.last = (x == w - 1) && (y == h - 1);
                    sb.push_back(it);
                    n++;
                end
            end
        end
    endtask

    task automatic start_cu(input int w, input int h, input int base);
        start     = 1'b1;
        cu_w_blk  = 6'(w);
        cu_h_blk  = 6'(h);
        base_addr = 13'(base);
        t0        = cyc;
        tick();
        start     = 1'b0;
        cu_w_blk  = 6'($urandom);
        cu_h_blk  = 6'($urandom);
        base_addr = 13'($urandom);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 128'(done_cnt - d0), 128'(1));
    endtask

    task automatic run_cu(input int w, input int h, input int base);
        int d0, e0;
        d0 = done_cnt;
        e0 = exports.size();
        push_cu(w, h, base, w * h);
        start_cu(w, h, base);
        wait_done(d0, w * h * 40 + 40);
        chk("export_count", 128'(exports.size() - e0), 128'(w * h));
        chk("sb_drained", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        int d0, e0, b0, hc, n, w, h;
        logic [51:0]  sa;
        logic [127:0] sd;
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;

        // Reset with random inputs, start held high
        rst_n = 1'b0; start = 1'b1; abort = 1'($urandom); blk_ready = 1'($urandom);
        cu_w_blk = 6'($urandom); cu_h_blk = 6'($urandom); base_addr = 13'($urandom);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ctrl", 128'({busy, done, cur_en, cur_export, blk_valid, blk_last}), 128'(0));
            chk("rst_addr", 128'({cur_addr0, cur_addr1, cur_addr2, cur_addr3}), 128'(0));
            chk("rst_data", {blk_data0, blk_data1, blk_data2, blk_data3}, 128'(0));
            chk("rst_xy", 128'({blk_x, blk_y}), 128'(0));
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; blk_ready = 1'b1;
        tick();
        chk("start_in_reset_ignored", 128'({busy, cur_export}), 128'(0));

        // 2x2 at base 0, ready high, with a stray start mid-run
        d0 = done_cnt; e0 = exports.size(); b0 = busy_cnt;
        push_cu(2, 2, 0, 4);
        start_cu(2, 2, 0);
        for (int i = 0; i < 3; i++) tick();
        start = 1'b1; cu_w_blk = 6'd3; cu_h_blk = 6'd3; base_addr = 13'd100;
        tick();
        start = 1'b0;
        wait_done(d0, 100);
        chk("2x2_export_count", 128'(exports.size() - e0), 128'(4));
        for (int i = 0; i < 4; i++)
            if (exports.size() > e0 + i)
                chk("2x2_export_cycle", 128'(exports[e0 + i]), 128'(1 + 3 * i));
        chk("2x2_done_cycle", 128'(done_rel), 128'(13));
        chk("2x2_busy_after", 128'(busy), 128'(0));
        chk("2x2_busy_cycles", 128'(busy_cnt - b0), 128'(13));
        chk("2x2_sb_drained", 128'(sb.size()), 128'(0));
        tick();

        // Backpressure in HOLD
        blk_ready = 1'b0;
        d0 = done_cnt;
        push_cu(2, 1, 50, 2);
        start_cu(2, 1, 50);
        n = 0;
        while (!blk_valid && n < 20) begin tick(); n++; end
        chk("bp_valid_seen", 128'(blk_valid), 128'(1));
        sa = {cur_addr0, cur_addr1, cur_addr2, cur_addr3};
        sd = {blk_data0, blk_data1, blk_data2, blk_data3};
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", 128'({blk_valid, cur_export}), 128'(2'b10));
            chk("bp_addr_stable", 128'({cur_addr0, cur_addr1, cur_addr2, cur_addr3}), 128'(sa));
            chk("bp_data_stable", {blk_data0, blk_data1, blk_data2, blk_data3}, sd);
            tick();
        end
        blk_ready = 1'b1;
        hc = cyc;
        tick();
        chk("bp_next_export", 128'({cur_export, cyc - hc}), 128'({1'b1, 32'd1}));
        wait_done(d0, 100);
        chk("bp_sb_drained", 128'(sb.size()), 128'(0));

        // Address wrap
        run_cu(1, 1, 8190);
        chk("wrap_addr", 128'(last_a), 128'({13'd8190, 13'd8191, 13'd0, 13'd1}));
        chk("wrap_last", 128'(last_last), 128'(1));

        // Zero-size CU
        d0 = done_cnt; e0 = exports.size(); b0 = busy_cnt;
        start_cu(0, 3, 5);
        wait_done(d0, 20);
        tick();
        chk("zero_done_cycle", 128'(done_rel), 128'(1));
        chk("zero_exports", 128'(exports.size() - e0), 128'(0));
        chk("zero_busy_cycles", 128'(busy_cnt - b0), 128'(1));

        // Abort in WAIT of the second sub-block
        d0 = done_cnt; e0 = exports.size();
        push_cu(2, 2, 0, 1);
        start_cu(2, 2, 0);
        n = 0;
        while (exports.size() - e0 < 2 && n < 20) begin tick(); n++; end
        chk("abort_reached_wait", 128'(exports.size() - e0), 128'(2));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 128'({busy, blk_valid, cur_export}), 128'(0));
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
        chk("abort_sb_drained", 128'(sb.size()), 128'(0));
        run_cu(3, 2, 1234);

        // Randomized runs with random backpressure, plus extreme dimensions
        rand_rdy = 1'b1;
        run_cu(32, 2, $urandom_range(0, 8191));
        run_cu(1, 32, $urandom_range(0, 8191));
        for (int i = 0; i < 24; i++) begin
            w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            h = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            run_cu(w, h, $urandom_range(0, 8191));
        end
        rand_rdy = 1'b0;
        blk_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("final_idle", 128'(busy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cur_blk_sched.md
# cur_blk_sched

Read scheduler for the current-CU pixel RAM (`cur_data`) in the affine motion-estimation datapath. On `start`, it walks a CU in 4x4 sub-blocks, in raster order. For each sub-block it drives the four row addresses and the one-cycle `export_data_cur` strobe into `cur_data`. It then captures the returned 4x32-bit sub-block and hands it downstream (SAD / affine prediction) over a valid/ready handshake. It owns `cur_data`'s `en` and `export_data_cur`; `load_cur_ram` stays with the loader.

## Interface
- ADDR_W, 13, word address width of `cur_data` (one word = 4 pixels x 8 bit)
- DATA_W, 32, word width
- RD_LAT, 1, cycles from the export strobe to valid `cur_data0..3`; legal range 1..4

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- abort  in  1  synchronous cancel of the current run
- cu_w_blk  in  6  CU width in 4-pixel columns, 0..32; sampled on accepted start
- cu_h_blk  in  6  CU height in 4-pixel rows, 0..32; sampled on accepted start
- base_addr  in  ADDR_W  word address of CU pixel (0,0); sampled on accepted start
- busy  out  1  high from the accepted start until return to IDLE
- done  out  1  one-cycle pulse after the last sub-block handshake
- cur_en  out  1  to `cur_data.en`; equals busy
- cur_export  out  1  to `cur_data.export_data_cur`; one-cycle strobe per sub-block
- cur_addr0..3  out  ADDR_W each  row addresses of the current sub-block
- cur_data0..3  in  DATA_W each  sub-block rows returned by `cur_data`
- blk_valid  out  1  output sub-block valid
- blk_ready  in  1  downstream accepts
- blk_data0..3  out  DATA_W each  captured rows 0..3
- blk_x, blk_y  out  5 each  sub-block column/row index
- blk_last  out  1  marks the final sub-block of the CU

## Operation
- States:
  - IDLE: if `start`, latch w/h/base and clear bx, by. If w==0 or h==0, go to FIN; otherwise go to ISSUE.
  - ISSUE: one cycle. `cur_export=1` with addresses valid. Go to WAIT.
  - WAIT: RD_LAT cycles. In the final WAIT cycle, capture `cur_data0..3` into `blk_data0..3`, set `blk_valid`, go to HOLD.
  - HOLD: on `blk_valid && blk_ready`, clear `blk_valid`. If last, go to FIN; otherwise advance indices and go to ISSUE.
  - FIN: `done=1` for one cycle, then IDLE.
- Row pointer `rp` = address of row 0 of the current sub-block. Outputs: `cur_addr_k = rp + k*cu_w_blk`, k=0..3. All arithmetic is modulo 2^ADDR_W (silent wrap).
- Advance: if bx < w-1, then bx+1 and rp+1. Otherwise bx=0, by+1, and rp = row start + 4*cu_w_blk, where row start is tracked separately.
- `blk_last` = (bx==w-1 && by==h-1), registered together with the captured data.
- `cur_addr0..3`, `blk_x`, `blk_y` stay stable from ISSUE through the HOLD handshake. `blk_data*` is stable while `blk_valid` is high.
- `start` while busy is ignored. Latched parameters do not change mid-run.
- `abort` (any non-IDLE state) goes to IDLE next cycle:
  - clears `blk_valid` and `busy`;
  - does not pulse `done`;
  - if asserted in ISSUE, still lets that strobe stand.
  - `abort` outranks `start` and handshake in the same cycle.
- `rst_n` low has priority over everything, including mid-run.

## Timing
- Reset values: every output is 0, FSM is IDLE, counters and `rp` are 0.
- `start` at cycle 0 gives `busy=1` and state ISSUE at cycle 1, with the first `cur_export` at cycle 1.
- Per sub-block with `blk_ready` held high: RD_LAT+2 cycles (ISSUE, WAIT x RD_LAT, HOLD). For RD_LAT=1 that is one export every 3 cycles.
- Data captured in the last WAIT cycle appears on `blk_data*` with `blk_valid` in the following (HOLD) cycle.
- The next `cur_export` comes one cycle after the HOLD handshake. No read is issued while `blk_valid` is pending, so there is no overflow path.
- `done` rises one cycle after the final handshake; `busy` falls in the same cycle `done` falls.
- Zero-size CU: `start` at cycle 0 gives FIN at cycle 1 (`done=1`, no export) and IDLE at cycle 2.

## Test plan
- Reset: assert `rst_n=0` for 2 cycles with random inputs -> all outputs 0; `start` during reset is ignored.
- 2x2 CU, base=0, `blk_ready`=1, RD_LAT=1 -> exports at cycles 1, 4, 7, 10. Addresses in order: {0,2,4,6}, {1,3,5,7}, {8,10,12,14}, {9,11,13,15}. `blk_x/blk_y` = (0,0), (1,0), (0,1), (1,1). `blk_last` only on the 4th. `done` at cycle 13.
- Backpressure: hold `blk_ready`=0 for 5 cycles in HOLD -> `blk_valid`, `blk_data*` and addresses stable; no `cur_export`; the next export comes 1 cycle after ready rises.
- Wrap: base=8190, w=1, h=1 -> addresses {8190, 8191, 0, 1}; `blk_last=1`; one `done`.
- Zero size: w=0, h=3 -> `done` at cycle 1, no `cur_export`, `busy` high for 1 cycle.
- Control: `start` while busy is ignored (count stays 4 sub-blocks for 2x2). `abort` in WAIT of sub-block 2 -> IDLE next cycle, `blk_valid=0`, no `done`. A fresh `start` then runs a full CU correctly.
